// File: rtl/lsu_pkg.sv
// Shared constants, funct3 width codes, FSM state type and the access legality
// check for the load/store unit.
package lsu_pkg;

    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        RESP
    } lsu_state_t;

    // Stores only have signed widths; unsigned codes are load-only.
    function automatic logic access_err(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
        logic err;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = off[0];
            F3_W:    err = (off != 2'b00);
            F3_BU:   err = is_store;
            F3_HU:   err = is_store | off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and data_mem signals of the load/store unit.
interface lsu_if;
    import lsu_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic [RADDR-1:0] req_rd;

    logic             mem_gwe;
    logic             mem_rd;
    logic             mem_bw0;
    logic             mem_bw1;
    logic             mem_bw2;
    logic             mem_bw3;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [XLEN-1:0]  mem_rdata;

    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [RADDR-1:0] resp_rd;
    logic             resp_load;
    logic             resp_err;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_rdata, resp_ready,
        output req_ready,
        output mem_gwe, mem_rd, mem_bw0, mem_bw1, mem_bw2, mem_bw3, mem_addr, mem_wdata,
        output resp_valid, resp_data, resp_rd, resp_load, resp_err
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_rdata, resp_ready,
        input  req_ready,
        input  mem_gwe, mem_rd, mem_bw0, mem_bw1, mem_bw2, mem_bw3, mem_addr, mem_wdata,
        input  resp_valid, resp_data, resp_rd, resp_load, resp_err
    );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a 32-bit read word and
// sign- or zero-extends it according to funct3.
module load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[{offset, 3'b000} +: 8];
        half_v = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h0, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes requests into data_mem strobes, waits out the
// registered read, and returns aligned load data or an error response.
module lsu
    import lsu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_t       state_q, state_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;
    logic [RADDR-1:0] resp_rd_q, resp_rd_d;
    logic             resp_load_q, resp_load_d;
    logic             resp_err_q, resp_err_d;
    logic [1:0]       off_q, off_d;
    logic [2:0]       f3_q, f3_d;

    logic             accept;
    logic             req_err;
    logic [XLEN-1:0]  aligned_data;

    load_align u_align (
        .rdata  (bus.mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (aligned_data)
    );

    // data_mem lane-steers by addr[1:0] itself, so address and data pass through unshifted.
    always_comb begin
        bus.req_ready = (state_q == IDLE) && !rst;
        accept        = bus.req_valid && bus.req_ready;
        req_err       = access_err(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
        bus.mem_addr  = bus.req_addr;
        bus.mem_wdata = bus.req_wdata;
        bus.mem_gwe   = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_bw0   = 1'b0;
        bus.mem_bw1   = 1'b0;
        bus.mem_bw2   = 1'b0;
        bus.mem_bw3   = 1'b0;
        if (accept && !req_err) begin
            if (!bus.req_store) begin
                bus.mem_rd = 1'b1;
            end else if (bus.req_funct3 == F3_W) begin
                bus.mem_gwe = 1'b1;
            end else if (bus.req_funct3 == F3_H) begin
                bus.mem_bw0 = !bus.req_addr[1];
                bus.mem_bw1 = !bus.req_addr[1];
                bus.mem_bw2 = bus.req_addr[1];
                bus.mem_bw3 = bus.req_addr[1];
            end else begin
                bus.mem_bw0 = (bus.req_addr[1:0] == 2'd0);
                bus.mem_bw1 = (bus.req_addr[1:0] == 2'd1);
                bus.mem_bw2 = (bus.req_addr[1:0] == 2'd2);
                bus.mem_bw3 = (bus.req_addr[1:0] == 2'd3);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_load_d  = resp_load_q;
        resp_err_d   = resp_err_q;
        off_d        = off_q;
        f3_d         = f3_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    resp_rd_d = bus.req_rd;
                    if (!bus.req_store && !req_err) begin
                        state_d = LOAD_WAIT;
                        off_d   = bus.req_addr[1:0];
                        f3_d    = bus.req_funct3;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        resp_load_d  = 1'b0;
                        resp_err_d   = req_err;
                    end
                end
            end
            LOAD_WAIT: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = aligned_data;
                resp_load_d  = 1'b1;
                resp_err_d   = 1'b0;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_load_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            off_q        <= '0;
            f3_q         <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_load_q  <= resp_load_d;
            resp_err_q   <= resp_err_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_load  = resp_load_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: emulates data_mem and compares every response
// against a byte-array reference model.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lsu_if bus();

    lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] dmem [0:15];
    logic [31:0] rdata_q;
    logic [7:0]  ref_mem [0:63];

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] bw, input logic [1:0] off);
        logic [31:0] w;
        w = old;
        for (int k = 0; k < 4; k++)
            if (bw[k] && k >= int'(off)) w[8*k +: 8] = wd[8*(k - int'(off)) +: 8];
        return w;
    endfunction

    // Stand-in for data_mem: byte lanes take the low bytes of wdata starting at addr[1:0].
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) dmem[i] <= init_word(i);
        end else if (bus.mem_gwe) begin
            dmem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        end else if (bus.mem_bw0 | bus.mem_bw1 | bus.mem_bw2 | bus.mem_bw3) begin
            dmem[bus.mem_addr[5:2]] <= lane_merge(dmem[bus.mem_addr[5:2]], bus.mem_wdata,
                {bus.mem_bw3, bus.mem_bw2, bus.mem_bw1, bus.mem_bw0}, bus.mem_addr[1:0]);
        end
        if (bus.mem_rd) rdata_q <= dmem[bus.mem_addr[5:2]];
    end

    assign bus.mem_rdata = rdata_q;

    function automatic logic exp_err(input logic st, input logic [2:0] f3, input logic [31:0] a);
        logic illegal, mis;
        illegal = st ? !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                     : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'd0);
        return illegal || mis;
    endfunction

    // Packed as {gwe, rd, bw3, bw2, bw1, bw0}.
    function automatic logic [5:0] exp_strobes(input logic st, input logic [2:0] f3, input logic [31:0] a);
        if (exp_err(st, f3, a)) return 6'b0;
        if (!st) return 6'b010000;
        if (f3 == 3'd2) return 6'b100000;
        if (f3 == 3'd1) return {2'b00, 4'(4'b0011 << a[1:0])};
        return {2'b00, 4'(4'b0001 << a[1:0])};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int   base;
        logic [15:0] h;
        base = int'(a[5:0]);
        case (f3)
            3'd0: return {{24{ref_mem[base][7]}}, ref_mem[base]};
            3'd4: return {24'h0, ref_mem[base]};
            3'd1: begin h = {ref_mem[base+1], ref_mem[base]}; return {{16{h[15]}}, h}; end
            3'd5: return {16'h0, ref_mem[base+1], ref_mem[base]};
            default: return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = (f3 == 3'd2) ? 4 : (f3 == 3'd1) ? 2 : 1;
        for (int i = 0; i < n; i++) ref_mem[int'(a[5:0]) + i] = wd[8*i +: 8];
    endtask

    task automatic ref_init();
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
    endtask

    function automatic logic [5:0] strobes();
        return {bus.mem_gwe, bus.mem_rd, bus.mem_bw3, bus.mem_bw2, bus.mem_bw1, bus.mem_bw0};
    endfunction

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
    endtask

    // One full transaction with resp_ready held low for 'stall' cycles of RESP.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input int stall);
        logic        e;
        logic [5:0]  es;
        logic [31:0] ed;
        e  = exp_err(st, f3, a);
        es = exp_strobes(st, f3, a);
        ed = (st || e) ? 32'h0 : ref_load(f3, a);
        @(negedge clk);
        drive(st, f3, a, wd, rd);
        bus.resp_ready = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL accept_ready a=%h got=%b exp=1", a, bus.req_ready);
        end
        checks++;
        if (strobes() !== es) begin
            errors++; $display("[TB] FAIL strobes st=%b f3=%0d a=%h got=%b exp=%b", st, f3, a, strobes(), es);
        end
        checks++;
        if (bus.mem_addr !== a || bus.mem_wdata !== wd) begin
            errors++; $display("[TB] FAIL mem_bus got=%h/%h exp=%h/%h", bus.mem_addr, bus.mem_wdata, a, wd);
        end
        @(posedge clk);
        if (st && !e) ref_store(f3, a, wd);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if (strobes() !== 6'b0) begin
            errors++; $display("[TB] FAIL strobe_pulse got=%b exp=000000", strobes());
        end
        if (!st && !e) begin
            checks++;
            if (bus.resp_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL load_wait_valid got=%b exp=0", bus.resp_valid);
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL resp_timing valid/ready got=%b%b exp=10", bus.resp_valid, bus.req_ready);
        end
        checks++;
        if (bus.resp_data !== ed) begin
            errors++; $display("[TB] FAIL resp_data st=%b f3=%0d a=%h got=%h exp=%h", st, f3, a, bus.resp_data, ed);
        end
        checks++;
        if ({bus.resp_err, bus.resp_load, bus.resp_rd} !== {e, !st && !e, rd}) begin
            errors++; $display("[TB] FAIL resp_flags err/load/rd got=%b/%b/%0d exp=%b/%b/%0d",
                               bus.resp_err, bus.resp_load, bus.resp_rd, e, !st && !e, rd);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== ed || bus.req_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL stall_hold cyc=%0d valid=%b data=%h ready=%b exp 1/%h/0",
                                   i, bus.resp_valid, bus.resp_data, bus.req_ready, ed);
            end
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL release valid/ready got=%b%b exp=01", bus.resp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_init = 1'b1;
        bus.resp_ready = 1'b0;
        drive(1'b0, F3_W, 32'h10, 32'h0, 5'd1);
        ref_init();
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || strobes() !== 6'b0) begin
            errors++; $display("[TB] FAIL reset_gate ready=%b strobes=%b exp 0/000000", bus.req_ready, strobes());
        end
        rst = 1'b0;
        mem_init = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_load, bus.resp_err} !== 40'h0) begin
            errors++; $display("[TB] FAIL reset_values valid=%b data=%h rd=%0d load=%b err=%b exp all 0",
                               bus.resp_valid, bus.resp_data, bus.resp_rd, bus.resp_load, bus.resp_err);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    task automatic test_word();
        do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 5'd3, 0);
        do_req(1'b0, F3_W, 32'h10, 32'h0, 5'd4, 0);
    endtask

    task automatic test_byte();
        do_req(1'b1, F3_B, 32'h13, 32'h000000A5, 5'd0, 0);
        do_req(1'b0, F3_B, 32'h13, 32'h0, 5'd6, 0);
        do_req(1'b0, F3_BU, 32'h13, 32'h0, 5'd7, 0);
    endtask

    task automatic test_half();
        do_req(1'b1, F3_H, 32'h22, 32'h00008001, 5'd0, 0);
        do_req(1'b0, F3_H, 32'h22, 32'h0, 5'd8, 0);
        do_req(1'b0, F3_HU, 32'h22, 32'h0, 5'd9, 0);
    endtask

    task automatic test_errors();
        do_req(1'b0, F3_W, 32'h15, 32'h0, 5'd10, 0);
        do_req(1'b1, F3_H, 32'h17, 32'h12345678, 5'd11, 0);
        do_req(1'b0, 3'b011, 32'h14, 32'h0, 5'd12, 0);
        do_req(1'b1, F3_BU, 32'h14, 32'hFFFFFFFF, 5'd13, 0);
        do_req(1'b0, F3_W, 32'h14, 32'h0, 5'd14, 0);
    endtask

    task automatic test_stall();
        do_req(1'b0, F3_W, 32'h10, 32'h0, 5'd15, 5);
        do_req(1'b1, F3_B, 32'h11, 32'h0000005C, 5'd16, 3);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        drive(1'b0, F3_W, 32'h20, 32'h0, 5'd17);
        bus.resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b0 || strobes() !== 6'b0) begin
            errors++; $display("[TB] FAIL rst_wait_gate ready=%b strobes=%b exp 0/000000", bus.req_ready, strobes());
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_wait_idle valid/ready got=%b%b exp=01", bus.resp_valid, bus.req_ready);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_wait_discard got=%b exp=0", bus.resp_valid);
        end
    endtask

    // resp_ready held high: stores every 2 cycles, loads every 3.
    task automatic test_back_to_back();
        logic [31:0] wd;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wd = $urandom;
            drive(1'b1, F3_W, 32'(32 + 4*i), wd, 5'(i));
            #1;
            checks++;
            if (bus.req_ready !== 1'b1 || bus.mem_gwe !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_store_accept i=%0d ready/gwe got=%b%b exp=11", i, bus.req_ready, bus.mem_gwe);
            end
            @(posedge clk);
            ref_store(F3_W, 32'(32 + 4*i), wd);
            @(negedge clk);
            #1;
            checks++;
            if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.mem_gwe !== 1'b0) begin
                errors++; $display("[TB] FAIL b2b_store_resp i=%0d ready/valid/gwe got=%b%b%b exp=010",
                                   i, bus.req_ready, bus.resp_valid, bus.mem_gwe);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1'b0, F3_W, 32'(32 + 4*i), 32'h0, 5'(20 + i));
            #1;
            checks++;
            if (bus.req_ready !== 1'b1 || bus.mem_rd !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_load_accept i=%0d ready/rd got=%b%b exp=11", i, bus.req_ready, bus.mem_rd);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL b2b_load_wait i=%0d valid/ready got=%b%b exp=00", i, bus.resp_valid, bus.req_ready);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== ref_load(F3_W, 32'(32 + 4*i))) begin
                errors++; $display("[TB] FAIL b2b_load_data i=%0d valid=%b got=%h exp=%h",
                                   i, bus.resp_valid, bus.resp_data, ref_load(F3_W, 32'(32 + 4*i)));
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 60));
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == F3_W) a[1:0] = 2'b00;
                else if (f3 == F3_H || f3 == F3_HU) a[0] = 1'b0;
            end
            do_req(st, f3, a, $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.req_rd     = 5'd0;
        bus.resp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_stall();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
